// File: rtl/mem_stage_if.sv
// Pipeline channels around the MEM stage: EX->MEM (es_ms_if) and MEM->WB (ms_ws_if).
// Handshake: a transfer happens on a rising clk edge where valid & allowin are both 1.
// Valid never depends on the allowin of its own channel, and the payload is stable while valid is held.

interface es_ms_if;
  logic         es2ms_valid;
  logic         ms_allowin;
  logic [122:0] es2ms_bus;
  logic [39:0]  es_rf_zip;
  logic         ms_ex_to_es;

  modport master (output es2ms_valid, es2ms_bus, es_rf_zip,
                  input  ms_allowin, ms_ex_to_es);
  modport slave  (input  es2ms_valid, es2ms_bus, es_rf_zip,
                  output ms_allowin, ms_ex_to_es);
endinterface

interface ms_ws_if;
  logic         ms2ws_valid;
  logic         ws_allowin;
  logic [116:0] ms2ws_bus;
  logic [38:0]  ms_rf_zip;
  logic         wb_ex;
  logic         ertn_flush;

  modport master (output ms2ws_valid, ms2ws_bus, ms_rf_zip,
                  input  ws_allowin, wb_ex, ertn_flush);
  modport slave  (input  ms2ws_valid, ms2ws_bus, ms_rf_zip,
                  output ws_allowin, wb_ex, ertn_flush);
endinterface

// File: rtl/mem_stage.sv
// LoongArch MEM stage: waits for the data-SRAM response, buffers it against WB back-pressure,
// extracts load data and drops the stale response left behind by a flush.

module mem_stage (
  input  logic          clk,
  input  logic          resetn,
  es_ms_if.slave        es_if,
  ms_ws_if.master       ws_if,
  input  logic          data_sram_data_ok,
  input  logic [31:0]   data_sram_rdata,
  output logic [39:0]   ms_fwd_zip,
  output logic [2:0]    dbg_state_o
);

  logic        ms_valid_q;
  logic        discard_q, discard_d;
  logic        data_buf_vld_q, data_buf_vld_d;
  logic [31:0] data_buf_q, data_buf_d;

  logic [31:0] pc_q;
  logic [4:0]  ld_op_q;
  logic        mem_req_q;
  logic [84:0] except_q;
  logic        csr_re_q;
  logic        res_from_mem_q;
  logic        rf_we_q;
  logic [4:0]  rf_waddr_q;
  logic [31:0] alu_result_q;

  logic        flush;
  logic        resp_ok;
  logic        ms_ready_go;
  logic        ms_allowin;
  logic        ms2ws_valid;
  logic [31:0] ld_raw;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;
  logic [31:0] rf_wdata;

  assign flush       = ws_if.wb_ex | ws_if.ertn_flush;
  assign resp_ok     = data_sram_data_ok & ~discard_q;
  assign ms_ready_go = ~mem_req_q | data_buf_vld_q | resp_ok;
  assign ms_allowin  = ~ms_valid_q | (ms_ready_go & ws_if.ws_allowin);
  assign ms2ws_valid = ms_valid_q & ms_ready_go;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      ms_valid_q <= 1'b0;
    end else if (flush) begin
      ms_valid_q <= 1'b0;
    end else if (ms_allowin) begin
      ms_valid_q <= es_if.es2ms_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      pc_q           <= 32'd0;
      ld_op_q        <= 5'd0;
      mem_req_q      <= 1'b0;
      except_q       <= 85'd0;
      csr_re_q       <= 1'b0;
      res_from_mem_q <= 1'b0;
      rf_we_q        <= 1'b0;
      rf_waddr_q     <= 5'd0;
      alu_result_q   <= 32'd0;
    end else if (es_if.es2ms_valid && ms_allowin) begin
      {pc_q, ld_op_q, mem_req_q, except_q} <= es_if.es2ms_bus;
      {csr_re_q, res_from_mem_q, rf_we_q, rf_waddr_q, alu_result_q} <= es_if.es_rf_zip;
    end
  end

  // A flush while the request is still in flight leaves one response to swallow later.
  always_comb begin
    discard_d = discard_q;
    if (flush && ms_valid_q && mem_req_q && !data_buf_vld_q && !data_sram_data_ok) begin
      discard_d = 1'b1;
    end else if (discard_q && data_sram_data_ok) begin
      discard_d = 1'b0;
    end
  end

  always_comb begin
    data_buf_vld_d = data_buf_vld_q;
    data_buf_d     = data_buf_q;
    if (flush) begin
      data_buf_vld_d = 1'b0;
    end else if (ms2ws_valid && ws_if.ws_allowin) begin
      data_buf_vld_d = 1'b0;
    end else if (ms_valid_q && mem_req_q && resp_ok && !data_buf_vld_q) begin
      data_buf_vld_d = 1'b1;
      data_buf_d     = data_sram_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      discard_q      <= 1'b0;
      data_buf_vld_q <= 1'b0;
      data_buf_q     <= 32'd0;
    end else begin
      discard_q      <= discard_d;
      data_buf_vld_q <= data_buf_vld_d;
      data_buf_q     <= data_buf_d;
    end
  end

  assign ld_raw = data_buf_vld_q ? data_buf_q : data_sram_rdata;

  // ld_op is one-hot {b, bu, h, hu, w}.
  always_comb begin
    ld_byte = 8'd0;
    ld_half = alu_result_q[1] ? ld_raw[31:16] : ld_raw[15:0];
    case (alu_result_q[1:0])
      2'd0:    ld_byte = ld_raw[7:0];
      2'd1:    ld_byte = ld_raw[15:8];
      2'd2:    ld_byte = ld_raw[23:16];
      default: ld_byte = ld_raw[31:24];
    endcase
    if (ld_op_q[4])      ld_ext = {{24{ld_byte[7]}}, ld_byte};
    else if (ld_op_q[3]) ld_ext = {24'd0, ld_byte};
    else if (ld_op_q[2]) ld_ext = {{16{ld_half[15]}}, ld_half};
    else if (ld_op_q[1]) ld_ext = {16'd0, ld_half};
    else                 ld_ext = ld_raw;
  end

  assign rf_wdata = res_from_mem_q ? ld_ext : alu_result_q;

  assign es_if.ms_allowin  = ms_allowin;
  // except_zip[5:0] holds the exception/ertn flags; the upper bits carry CSR payload.
  assign es_if.ms_ex_to_es = ms_valid_q & (|except_q[5:0]);

  assign ws_if.ms2ws_valid = ms2ws_valid;
  assign ws_if.ms2ws_bus   = {pc_q, except_q};
  assign ws_if.ms_rf_zip   = {csr_re_q, rf_we_q, rf_waddr_q, rf_wdata};

  assign ms_fwd_zip = {ms_valid_q & (res_from_mem_q | csr_re_q) & ~ms2ws_valid,
                       csr_re_q, rf_we_q & ms_valid_q, rf_waddr_q, rf_wdata};

  assign dbg_state_o = {discard_q, data_buf_vld_q, ms_valid_q};

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: stimulus pushes expected WB transfers into a queue,
// a monitor pops and compares on each MEM->WB handshake.

module tb_mem_stage;

  logic        clk;
  logic        resetn;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic [39:0] ms_fwd_zip;
  logic [2:0]  dbg_state;

  es_ms_if es_if ();
  ms_ws_if ws_if ();

  mem_stage dut (
    .clk               (clk),
    .resetn            (resetn),
    .es_if             (es_if.slave),
    .ws_if             (ws_if.master),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata),
    .ms_fwd_zip        (ms_fwd_zip),
    .dbg_state_o       (dbg_state)
  );

  localparam int W = 149;  // {pc, wdata, except_zip}
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  localparam logic [4:0] LD_B  = 5'b10000;
  localparam logic [4:0] LD_BU = 5'b01000;
  localparam logic [4:0] LD_HU = 5'b00010;
  localparam logic [4:0] LD_W  = 5'b00001;

  // clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (resetn && ws_if.ms2ws_valid && ws_if.ws_allowin) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL wb_unexpected: got pc %0h expected no transfer", ws_if.ms2ws_bus[116:85]);
      end else begin
        check("wb_transfer",
              {ws_if.ms2ws_bus[116:85], ws_if.ms_rf_zip[31:0], ws_if.ms2ws_bus[84:0]},
              exp_q.pop_front());
      end
    end
  end

  // drivers
  task automatic send(input logic [31:0] pc, input logic [4:0] ld_op, input logic mem_req,
                      input logic [84:0] ex, input logic rfm, input logic [4:0] wa,
                      input logic [31:0] alu);
    int n = 0;
    es_if.es2ms_valid = 1'b1;
    es_if.es2ms_bus   = {pc, ld_op, mem_req, ex};
    es_if.es_rf_zip   = {1'b0, rfm, 1'b1, wa, alu};
    @(negedge clk);
    while (!es_if.ms_allowin && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("send_accept", es_if.ms_allowin, 1);
    @(posedge clk);
    #1;
    es_if.es2ms_valid = 1'b0;
  endtask

  task automatic respond(input logic [31:0] rdata);
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = rdata;
    @(posedge clk);
    #1;
    data_sram_data_ok = 1'b0;
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] wdata, input logic [84:0] ex);
    exp_q.push_back({pc, wdata, ex});
  endtask

  logic [84:0] ex5;

  initial begin
    resetn            = 1'b0;
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = 32'd0;
    es_if.es2ms_valid = 1'b0;
    es_if.es2ms_bus   = '0;
    es_if.es_rf_zip   = '0;
    ws_if.ws_allowin  = 1'b1;
    ws_if.wb_ex       = 1'b0;
    ws_if.ertn_flush  = 1'b0;
    ex5 = {14'h00b, 1'b1, 32'hffff_0000, 32'h0000_0042, 6'b000010};
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;

    @(negedge clk);
    check("reset_state", dbg_state, 3'b000);
    check("reset_ms2ws_valid", ws_if.ms2ws_valid, 0);
    check("reset_allowin", es_if.ms_allowin, 1);
    check("reset_rf_we", ws_if.ms_rf_zip[37], 0);
    check("reset_ex_to_es", es_if.ms_ex_to_es, 0);
    check("reset_fwd_block", ms_fwd_zip[39], 0);
    @(posedge clk); #1;

    // loads with extraction
    push(32'h1c00_0000, 32'hffff_ff80, '0);
    send(32'h1c00_0000, LD_B, 1'b1, '0, 1'b1, 5'd5, 32'h0000_1003);
    @(negedge clk);
    check("t1_wait_no_valid", ws_if.ms2ws_valid, 0);
    @(posedge clk); #1;
    respond(32'h80ff_1234);
    @(negedge clk);
    check("t1_valid_one_cycle", ws_if.ms2ws_valid, 0);
    @(posedge clk); #1;

    push(32'h1c00_0004, 32'h0000_0080, '0);
    send(32'h1c00_0004, LD_BU, 1'b1, '0, 1'b1, 5'd5, 32'h0000_1003);
    respond(32'h80ff_1234);
    push(32'h1c00_0008, 32'h0000_80ff, '0);
    send(32'h1c00_0008, LD_HU, 1'b1, '0, 1'b1, 5'd6, 32'h0000_1002);
    respond(32'h80ff_1234);

    // WB back-pressure while the response arrives
    push(32'h1c00_0010, 32'hcafe_0001, '0);
    send(32'h1c00_0010, LD_W, 1'b1, '0, 1'b1, 5'd8, 32'h0000_0100);
    ws_if.ws_allowin  = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'hcafe_0001;
    @(negedge clk);
    check("t2_valid_on_data_ok", ws_if.ms2ws_valid, 1);
    @(posedge clk); #1;
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = 32'hdead_beef;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("t2_buf_vld", dbg_state[1], 1);
      check("t2_valid_held", ws_if.ms2ws_valid, 1);
      check("t2_wdata_stable", ws_if.ms_rf_zip[31:0], 32'hcafe_0001);
      @(posedge clk); #1;
    end
    ws_if.ws_allowin = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("t2_drained", dbg_state, 3'b000);
    @(posedge clk); #1;

    // load waiting: stall ID on dependency
    push(32'h1c00_0020, 32'h0000_abcd, '0);
    send(32'h1c00_0020, LD_W, 1'b1, '0, 1'b1, 5'd7, 32'h0000_0200);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("t3_allowin", es_if.ms_allowin, 0);
      check("t3_ms2ws_valid", ws_if.ms2ws_valid, 0);
      check("t3_fwd_block", ms_fwd_zip[39], 1);
      check("t3_fwd_we_addr", ms_fwd_zip[37:32], {1'b1, 5'd7});
      @(posedge clk); #1;
    end
    respond(32'h0000_abcd);

    // flush with request outstanding; stale response dropped
    send(32'h1c00_0030, LD_W, 1'b1, '0, 1'b1, 5'd9, 32'h0000_0300);
    ws_if.wb_ex = 1'b1;
    @(posedge clk); #1;
    ws_if.wb_ex = 1'b0;
    @(negedge clk);
    check("t4_discard_set", dbg_state, 3'b100);
    @(posedge clk); #1;
    push(32'h1c00_0040, 32'h2222_2222, '0);
    send(32'h1c00_0040, LD_W, 1'b1, '0, 1'b1, 5'd10, 32'h0000_0400);
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h1111_1111;
    @(negedge clk);
    check("t4_stale_ignored", ws_if.ms2ws_valid, 0);
    @(posedge clk); #1;
    data_sram_data_ok = 1'b0;
    @(negedge clk);
    check("t4_discard_clear", dbg_state, 3'b001);
    @(posedge clk); #1;
    respond(32'h2222_2222);

    // flush in the same cycle as data_ok: nothing to discard
    send(32'h1c00_0050, LD_W, 1'b1, '0, 1'b1, 5'd11, 32'h0000_0500);
    ws_if.ws_allowin  = 1'b0;
    ws_if.wb_ex       = 1'b1;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h3333_3333;
    @(posedge clk); #1;
    ws_if.wb_ex       = 1'b0;
    data_sram_data_ok = 1'b0;
    ws_if.ws_allowin  = 1'b1;
    @(negedge clk);
    check("t4b_no_discard", dbg_state, 3'b000);
    @(posedge clk); #1;

    // ALU instruction carrying a syscall flag
    push(32'h1c00_0060, 32'h5555_aaaa, ex5);
    send(32'h1c00_0060, 5'd0, 1'b0, ex5, 1'b0, 5'd3, 32'h5555_aaaa);
    @(negedge clk);
    check("t5_ms2ws_valid", ws_if.ms2ws_valid, 1);
    check("t5_ex_to_es", es_if.ms_ex_to_es, 1);
    check("t5_bus", ws_if.ms2ws_bus, {32'h1c00_0060, ex5});
    @(posedge clk); #1;
    @(negedge clk);
    check("t5_ex_to_es_gone", es_if.ms_ex_to_es, 0);
    @(posedge clk); #1;

    // reset while waiting with discard pending
    send(32'h1c00_0070, LD_W, 1'b1, '0, 1'b1, 5'd12, 32'h0000_0700);
    ws_if.ertn_flush = 1'b1;
    @(posedge clk); #1;
    ws_if.ertn_flush = 1'b0;
    send(32'h1c00_0080, LD_W, 1'b1, '0, 1'b1, 5'd13, 32'h0000_0800);
    @(negedge clk);
    check("t6_pre_reset", dbg_state, 3'b101);
    @(posedge clk); #1;
    resetn = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("t6_state_cleared", dbg_state, 3'b000);
    check("t6_ms2ws_valid", ws_if.ms2ws_valid, 0);
    check("t6_allowin", es_if.ms_allowin, 1);
    resetn = 1'b1;
    @(posedge clk); #1;

    repeat (3) @(posedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access pipeline stage of the five-stage LoongArch core. Sits between the execute stage (EX) and the write-back stage (WB).
- Accepts an instruction and its ALU result from EX, then waits for the data-SRAM response of an issued load or store. Extracts and extends load data.
- Forwards the packed exception/CSR payload unchanged to WB. Exports bypass information to ID and a cancel hint to EX.
- Buffers the one-cycle data_ok pulse so that WB back-pressure never loses load data. Discards a stale response after a pipeline flush.

Parameters:
- none (all widths fixed by the bus formats below)

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- es2ms_valid  in  1  EX holds a valid instruction for MEM
- ms_allowin  out  1  MEM can accept from EX this cycle
- es2ms_bus  in  123  {es_pc[31:0], es_ld_op[4:0], es_mem_req, es_except_zip[84:0]}
- es_rf_zip  in  40  {es_csr_re, es_res_from_mem, es_rf_we, es_rf_waddr[4:0], es_alu_result[31:0]}
- data_sram_data_ok  in  1  one-cycle pulse, response for the oldest outstanding request
- data_sram_rdata  in  32  read data, valid with data_ok
- ws_allowin  in  1  WB can accept
- wb_ex  in  1  exception flush from WB
- ertn_flush  in  1  ertn flush from WB
- ms2ws_valid  out  1  MEM presents a valid instruction to WB
- ms2ws_bus  out  117  {ms_pc[31:0], ms_except_zip[84:0]}
- ms_rf_zip  out  39  {ms_csr_re, ms_rf_we, ms_rf_waddr[4:0], ms_rf_wdata[31:0]}
- ms_fwd_zip  out  40  {ms_fwd_block, ms_csr_re, ms_rf_we&ms_valid, ms_rf_waddr, ms_rf_wdata}: ID bypass
- ms_ex_to_es  out  1  MEM holds a valid instruction with any exception or ertn flag; EX must suppress its memory request

Behaviour:
- Reset and clock: resetn synchronous, active-low; clock clk. Registers update on the posedge of clk.
- Reset values: ms_valid=0; discard=0; data_buf_vld=0; all payload registers 0.
  - Hence ms2ws_valid=0, ms_rf_we output 0, ms_ex_to_es=0, ms_fwd_block=0.
- ms_allowin = ~ms_valid | (ms_ready_go & ws_allowin).
- ms2ws_valid = ms_valid & ms_ready_go.
- ms_valid update:
  - if ~resetn: 0
  - else if wb_ex|ertn_flush: 0
  - else if ms_allowin: es2ms_valid
- Payload (es2ms_bus, es_rf_zip) latches when es2ms_valid & ms_allowin. It is held otherwise.
- ms_mem_req is latched from es2ms_bus. It is 1 for issued loads and stores, and 0 for ALE or excepted instructions.
- resp_ok = data_sram_data_ok & ~discard.
- ms_ready_go = ~ms_mem_req | data_buf_vld | resp_ok.
- data_buf:
  - If ms_valid & ms_mem_req & resp_ok & ~ws_allowin, then data_buf <= rdata and data_buf_vld <= 1.
  - data_buf_vld clears when the instruction leaves MEM (ms2ws_valid & ws_allowin), or on flush.
- Selected data: ld_raw = data_buf_vld ? data_buf : data_sram_rdata.
- Load extraction uses addr = alu_result[1:0] and one-hot ld_op {b, bu, h, hu, w}:
  - b/bu: byte ld_raw[8*addr +: 8], sign/zero extended to 32 bits.
  - h/hu: half ld_raw[16*addr[1] +: 16], sign/zero extended to 32 bits.
  - w: ld_raw unchanged.
- ms_rf_wdata = res_from_mem ? extracted : alu_result.
- ms_fwd_block = ms_valid & (res_from_mem | csr_re) & ~ms2ws_valid. ID must stall on a register match while it is 1.
- Flush with a request outstanding:
  - If wb_ex|ertn_flush arrives while ms_valid & ms_mem_req & ~data_buf_vld & ~data_sram_data_ok, then discard <= 1.
  - Flush in the same cycle as data_ok: discard stays 0.
- Discard clear: the next data_sram_data_ok while discard=1 clears discard. That pulse is not used by any instruction.
- At most one request is outstanding, so discard is one bit.
- Instruction arriving while discard=1: it waits. It is not satisfied by the discarded pulse.
- ms_ex_to_es = ms_valid & (OR of exception flag bits in ms_except_zip).
- ms_except_zip passes through unchanged. Masking by valid is WB's job.

Test Plan:
1. ld.b at addr 0x...3, rdata 0x80FF_1234, data_ok the cycle after entry, ws_allowin=1 -> ms_rf_wdata=0xFFFF_FF80 and ms2ws_valid=1 for exactly 1 cycle. ld.bu at the same address -> 0x0000_0080. ld.hu at addr 0x...2 -> 0x0000_80FF.
2. Load whose data_ok arrives with ws_allowin=0 for 3 cycles -> data_buf_vld=1, ms2ws_valid held at 1. Wdata stays stable at the captured value even though rdata changes to 0xDEAD_BEEF. Entry completes on the first cycle with ws_allowin=1.
3. Load waiting 2 cycles without data_ok -> ms_allowin=0, ms2ws_valid=0, ms_fwd_block=1. A dependent ID instruction sees the stall.
4. wb_ex pulse while a load is outstanding -> ms_valid=0 the next cycle, discard=1. A new ld.w enters. The first data_ok (rdata 0x1111_1111) is dropped. The second data_ok (0x2222_2222) completes with wdata=0x2222_2222.
5. ALU instruction with es_mem_req=0 and a syscall flag set -> ms2ws_valid the cycle after entry, ms_ex_to_es=1. ms2ws_bus equals the latched pc and except_zip bit-for-bit.
6. resetn low mid-wait with discard=1 -> all state reads 0 the next cycle, ms2ws_valid=0, ms_allowin=1.
